// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD serializer: digit constants, FSM states
// and the digit-count helper used to validate the DIGITS parameter.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        SCAN,
        EMIT
    } state_t;

    // Number of decimal digits needed to represent 2^width-1.
    function automatic int bcd_digits_for(input int width);
        longint unsigned max_val;
        int n;
        max_val = (64'd1 << width) - 64'd1;
        n = 1;
        while (max_val >= 64'd10) begin
            max_val = max_val / 64'd10;
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// Combinational add-3 correction: every nibble of the BCD register that is 5 or
// more gets 3 added, independently of its neighbours.
module bcd_dabble_step
    import bcd_pkg::*;
#(
    parameter int DIGITS = 5
) (
    input  logic [DIGITS*BCD_DIGIT_W-1:0] bcd_in,
    output logic [DIGITS*BCD_DIGIT_W-1:0] bcd_out
);

    always_comb begin
        bcd_out = bcd_in;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W] >= 4'd5) begin
                bcd_out[i*BCD_DIGIT_W +: BCD_DIGIT_W] = bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd3;
            end
        end
    end

endmodule

// File: rtl/bin_to_bcd_serializer.sv
// Sequential double-dabble converter that streams the resulting BCD digits out
// one per handshake, most significant first, with optional leading-zero suppression.
module bin_to_bcd_serializer
    import bcd_pkg::*;
#(
    parameter int BIN_W       = 16,
    parameter int DIGITS      = 5,
    parameter int SUPPRESS_LZ = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BIN_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_digit,
    output logic             out_last
);

    localparam int BCD_W = DIGITS * BCD_DIGIT_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int IDX_W = $clog2(DIGITS + 1);

    generate
        if (DIGITS < bcd_digits_for(BIN_W)) begin : g_bad_digits
            $error("bin_to_bcd_serializer: DIGITS too small for BIN_W");
        end
    endgenerate

    state_t                 state;
    state_t                 state_next;
    logic [BIN_W-1:0]       bin_reg;
    logic [BCD_W-1:0]       bcd_reg;
    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W+BIN_W-1:0] shifted;
    logic [CNT_W-1:0]       cnt;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       start_idx;
    logic [3:0]             cur_digit;

    bcd_dabble_step #(
        .DIGITS (DIGITS)
    ) u_step (
        .bcd_in  (bcd_reg),
        .bcd_out (bcd_adj)
    );

    assign shifted = {bcd_adj, bin_reg} << 1;

    // First digit to emit: the top digit, or the highest nonzero one when suppressing.
    always_comb begin
        start_idx = IDX_W'(DIGITS - 1);
        if (SUPPRESS_LZ != 0) begin
            start_idx = '0;
            for (int i = 1; i < DIGITS; i++) begin
                if (bcd_reg[i*BCD_DIGIT_W +: BCD_DIGIT_W] != 4'd0) begin
                    start_idx = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        cur_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_digit = bcd_reg[i*BCD_DIGIT_W +: BCD_DIGIT_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_reg <= '0;
            bcd_reg <= '0;
            cnt     <= '0;
            idx     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin_reg <= in_data;
                        bcd_reg <= '0;
                        cnt     <= '0;
                    end
                end
                CONVERT: begin
                    {bcd_reg, bin_reg} <= shifted;
                    cnt                <= cnt + CNT_W'(1);
                end
                SCAN: begin
                    idx <= start_idx;
                end
                EMIT: begin
                    if (out_ready && (idx != '0)) begin
                        idx <= idx - IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_digit  = 4'd0;
        out_last   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = CONVERT;
                end
            end
            CONVERT: begin
                if (cnt == CNT_W'(BIN_W - 1)) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                state_next = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                out_digit = cur_digit;
                out_last  = (idx == '0);
                if (out_ready && (idx == '0)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bin_to_bcd_serializer.sv
// Bench for bin_to_bcd_serializer: one default instance and one with leading-zero
// suppression, checked every cycle against a decimal-arithmetic queue model.
module tb_bin_to_bcd_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid  [2];
    logic [15:0] in_data   [2];
    logic        out_ready [2];
    logic        in_ready  [2];
    logic        out_valid [2];
    logic [3:0]  out_digit [2];
    logic        out_last  [2];

    int total = 0;
    int bad   = 0;

    bit         m_idle [2] = '{1'b1, 1'b1};
    int         m_wait [2] = '{0, 0};
    logic [3:0] m_q    [2][$];
    int         m_word [2];
    int         acc_cyc [2];
    bit         lat_taken [2];
    int         lat [2];
    int         cyc = 0;
    bit         rnd [2] = '{1'b0, 1'b0};

    int          coll_dec [2] = '{0, 0};
    logic [19:0] coll_hex [2] = '{20'h0, 20'h0};
    int          coll_n   [2] = '{0, 0};
    logic [19:0] done_hex [2];
    int          done_n   [2];

    always #5 clk = ~clk;

    bin_to_bcd_serializer #(.BIN_W(16), .DIGITS(5), .SUPPRESS_LZ(0)) dut0 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .in_data   (in_data[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .out_digit (out_digit[0]),
        .out_last  (out_last[0])
    );

    bin_to_bcd_serializer #(.BIN_W(16), .DIGITS(5), .SUPPRESS_LZ(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .in_data   (in_data[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .out_digit (out_digit[1]),
        .out_last  (out_last[1])
    );

    task automatic check_output(input string name, input int d, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s dut%0d: got 0x%0h want 0x%0h (t=%0t)", name, d, act, exp, $time);
        end
    endtask

    // Decimal digits of the value, MSD first; instance 1 drops leading zeros.
    function automatic void make_digits(input int d, input int value);
        int p;
        bit lead;
        p = 10000;
        lead = (d == 0);
        for (int k = 0; k < 5; k++) begin
            int dig;
            dig = (value / p) % 10;
            if (dig != 0 || k == 4) lead = 1'b1;
            if (lead) m_q[d].push_back(4'(dig));
            p = p / 10;
        end
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (reset) begin
                    m_idle[d] = 1'b1;
                    m_wait[d] = 0;
                    m_q[d].delete();
                end else if (m_idle[d]) begin
                    if (in_valid[d]) begin
                        m_idle[d]    = 1'b0;
                        m_wait[d]    = 17;
                        m_word[d]    = int'(in_data[d]);
                        acc_cyc[d]   = cyc;
                        lat_taken[d] = 1'b0;
                        make_digits(d, int'(in_data[d]));
                    end
                end else if (m_wait[d] > 0) begin
                    m_wait[d]--;
                end else if (out_ready[d]) begin
                    void'(m_q[d].pop_front());
                    if (m_q[d].size() == 0) m_idle[d] = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (reset) begin
                    check_output("rst_in_ready", d, int'(in_ready[d]), 1);
                    check_output("rst_out_valid", d, int'(out_valid[d]), 0);
                    check_output("rst_out_digit", d, int'(out_digit[d]), 0);
                    check_output("rst_out_last", d, int'(out_last[d]), 0);
                    coll_dec[d] = 0;
                    coll_hex[d] = '0;
                    coll_n[d]   = 0;
                end else begin
                    bit         exp_v;
                    int         exp_dig;
                    bit         exp_last;
                    exp_v    = !m_idle[d] && (m_wait[d] == 0);
                    exp_dig  = exp_v ? int'(m_q[d][0]) : 0;
                    exp_last = exp_v && (m_q[d].size() == 1);
                    check_output("in_ready", d, int'(in_ready[d]), int'(m_idle[d]));
                    check_output("out_valid", d, int'(out_valid[d]), int'(exp_v));
                    check_output("out_digit", d, int'(out_digit[d]), exp_dig);
                    check_output("out_last", d, int'(out_last[d]), int'(exp_last));
                    if (exp_v && !lat_taken[d]) begin
                        lat[d]       = cyc - acc_cyc[d];
                        lat_taken[d] = 1'b1;
                    end
                    if (exp_v && out_ready[d]) begin
                        check_output("digit_range", d, int'(out_digit[d] <= 4'd9), 1);
                        coll_hex[d] = {coll_hex[d][15:0], out_digit[d]};
                        coll_dec[d] = coll_dec[d] * 10 + int'(out_digit[d]);
                        coll_n[d]++;
                        if (exp_last) begin
                            check_output("decimal_value", d, coll_dec[d], m_word[d]);
                            done_hex[d] = coll_hex[d];
                            done_n[d]   = coll_n[d];
                            coll_dec[d] = 0;
                            coll_hex[d] = '0;
                            coll_n[d]   = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic apply_stimulus(input int d, input int value);
        int guard;
        @(posedge clk);
        #1;
        in_valid[d] = 1'b1;
        in_data[d]  = 16'(value);
        guard = 0;
        do begin
            @(posedge clk);
            #1;
            guard++;
        end while (m_idle[d] && guard < 100);
        if (m_idle[d]) check_output("accept_timeout", d, 0, 1);
        in_valid[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int guard;
        guard = 0;
        while (!m_idle[d] && guard < 3000) begin
            @(posedge clk);
            #1;
            guard++;
            if (rnd[d]) out_ready[d] = 1'($urandom_range(0, 1));
        end
        if (!m_idle[d]) check_output("idle_timeout", d, 0, 1);
    endtask

    task automatic check_word(input string name, input int d, input int hex_exp, input int n_exp);
        check_output({name, "_digits"}, d, int'(done_hex[d]), hex_exp);
        check_output({name, "_count"}, d, done_n[d], n_exp);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t_idle;
        int guard;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            in_data[d]   = '0;
            out_ready[d] = 1'b1;
            done_hex[d]  = '0;
            done_n[d]    = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        apply_stimulus(0, 0);
        wait_idle(0);
        check_word("zero", 0, 20'h00000, 5);
        check_output("latency", 0, lat[0], 17);

        apply_stimulus(0, 65535);
        wait_idle(0);
        check_word("max", 0, 20'h65535, 5);
        check_output("burst_len", 0, cyc - acc_cyc[0], 22);
        check_output("ready_after_last", 0, int'(in_ready[0]), 1);

        apply_stimulus(1, 42);
        wait_idle(1);
        check_word("lz42", 1, 20'h42, 2);
        apply_stimulus(1, 0);
        wait_idle(1);
        check_word("lz0", 1, 20'h0, 1);
        apply_stimulus(1, 10000);
        wait_idle(1);
        check_word("lz10000", 1, 20'h10000, 5);

        out_ready[0] = 1'b0;
        apply_stimulus(0, 12345);
        guard = 0;
        while (m_wait[0] != 0 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b1;
        in_data[0]   = 16'd777;
        repeat (3) begin
            @(negedge clk);
            check_output("hold_digit", 0, int'(out_digit[0]), 2);
            check_output("hold_valid", 0, int'(out_valid[0]), 1);
            @(posedge clk);
            #1;
        end
        out_ready[0] = 1'b1;
        wait_idle(0);
        t_idle = cyc;
        check_word("bp12345", 0, 20'h12345, 5);
        guard = 0;
        while (m_idle[0] && guard < 10) begin
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid[0] = 1'b0;
        check_output("accept_after_last", 0, acc_cyc[0] - t_idle, 1);
        wait_idle(0);
        check_word("late777", 0, 20'h00777, 5);

        apply_stimulus(0, 9999);
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_output("post_rst_ready", 0, int'(in_ready[0]), 1);
        check_output("post_rst_valid", 0, int'(out_valid[0]), 0);
        repeat (20) @(posedge clk);
        #1;
        apply_stimulus(0, 100);
        wait_idle(0);
        check_word("after_rst100", 0, 20'h00100, 5);

        rnd[0] = 1'b1;
        rnd[1] = 1'b1;
        fork
            begin
                for (int i = 0; i < 500; i++) begin
                    apply_stimulus(0, int'($urandom_range(0, 65535)));
                    wait_idle(0);
                end
            end
            begin
                for (int j = 0; j < 500; j++) begin
                    apply_stimulus(1, int'($urandom_range(0, 65535)));
                    wait_idle(1);
                end
            end
        join
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_serializer.md
Name: bin_to_bcd_serializer

Overview:
Converts a binary word into BCD digits using sequential double-dabble (shift-add-3), one iteration per cycle. It then emits the digits serially, one 4-bit digit per handshake, most significant digit first. It sits directly upstream of the per-cycle BCD-to-decimal digit stage and feeds it a stream of valid digits (0..9). Input and output use valid/ready handshakes. Conversions never overlap.

Parameters:
- BIN_W, 16, width of the binary input.
- DIGITS, 5, number of BCD digits held. Must satisfy DIGITS >= ceil(BIN_W*log10(2)); elaboration error otherwise.
- SUPPRESS_LZ, 0, when 1, leading zero digits are not emitted. At least one digit is always emitted.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-high reset.
- in_valid, input, 1, in_data is valid.
- in_ready, output, 1, block accepts a word (high only in IDLE).
- in_data, input, BIN_W, unsigned binary value to convert.
- out_valid, output, 1, out_digit is valid.
- out_ready, input, 1, downstream accepts the digit.
- out_digit, output, 4, current BCD digit, always 0..9.
- out_last, output, 1, marks the final digit of the current word.

Behaviour:
- Reset (async, active-high): state=IDLE; bin shift register, BCD register, iteration counter and digit index cleared. Output values:
  - out_valid=0, out_digit=0, out_last=0.
  - in_ready=1, since it is decoded from state IDLE.
- States: IDLE -> CONVERT -> SCAN -> EMIT -> IDLE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&&in_ready: load in_data into the bin shift register, clear the BCD register, set counter=0, go to CONVERT.
- CONVERT (exactly BIN_W cycles):
  - Each edge: every BCD nibble >=5 gets +3 (carry-free, nibble-local); then {bcd,bin} shifts left by 1.
  - The counter increments; when counter==BIN_W-1 the state goes to SCAN.
- SCAN (1 cycle):
  - SUPPRESS_LZ=0: start index = DIGITS-1.
  - SUPPRESS_LZ=1: start index = highest index holding a nonzero nibble, or 0 if all nibbles are zero.
  - Then go to EMIT.
- EMIT:
  - out_valid=1; out_digit=bcd[idx]; out_last=(idx==0).
  - On out_valid&&out_ready: if out_last, go to IDLE; otherwise idx decrements.
  - While out_ready=0, out_digit and out_last are held stable.
- Outputs outside EMIT: out_valid=0, out_digit=0, out_last=0.
- Latency: first out_valid is BIN_W+1 cycles after the accepting edge (17 at the default BIN_W=16). With out_ready held high, digits follow on consecutive cycles.
- Throughput: a new word is accepted only in IDLE.
  - in_ready is 0 from the accept edge until the edge after the final digit handshake.
  - in_valid/in_data are ignored while in_ready=0. No buffering, no error flag.
- Simultaneous events: the final-digit handshake and in_valid in the same cycle do NOT accept. in_ready is 0 in EMIT, so the word is accepted in the following IDLE cycle.
- Reset mid-operation (any state): the conversion is dropped immediately, with no partial digits emitted afterwards. The next accepted word converts correctly.
- Width rules:
  - The BCD register is DIGITS*4 bits.
  - The add-3 step is applied before every shift, including the first. This is harmless on zeros.
  - The maximum input 2^BIN_W-1 must never overflow the top nibble; the parameter check guarantees this.

Decomposition:
- Shared package bcd_pkg:
  - BCD_DIGIT_W=4 and BCD_MAX=4'd9.
  - State enum {IDLE, CONVERT, SCAN, EMIT}.
  - Function bcd_digits_for(width) returning the minimum DIGITS, used by the parameter check.
- Sub-module bcd_dabble_step (combinational, parameter DIGITS): per-nibble "if >=5 then +3" across the BCD register. Instantiated once in CONVERT.
- Counter, index and FSM stay in the top module.

Test Plan:
- Zero input, defaults: in_data=0 -> digits 0,0,0,0,0; out_last on the 5th; first out_valid 17 cycles after accept.
- Maximum input: in_data=65535, out_ready=1 -> 6,5,5,3,5 on 5 consecutive cycles; in_ready back to 1 the cycle after last.
- Leading-zero suppression: SUPPRESS_LZ=1, in_data=42 -> 4,2 with last on 2; in_data=0 -> single digit 0 with out_last=1; in_data=10000 -> 1,0,0,0,0.
- Backpressure: 12345 with out_ready=0 for 3 cycles while digit 2 is presented -> out_digit=2 held stable, full sequence 1,2,3,4,5 intact. in_valid with 777 during EMIT is ignored.
- Reset mid-CONVERT: 9999 accepted, reset pulsed at iteration 8 -> outputs 0, in_ready=1 after release, no digits emitted. Then 100 -> 0,0,1,0,0.
- Scoreboard, all scenarios: every emitted digit <=9; digits concatenate to the decimal value of the input. Random sweep of 1000 values with random out_ready.
